gcd_job_sequencer: RTL and testbench

//  Initiator for the gcd_calculator start/done interface. Accepts GCD jobs (a, b, tag)
//  on a valid/ready port and drives start/a/b into one engine. Waits for done,

---
 rtl/gcd_seq_pkg.sv | 15 +
 rtl/gcd_watchdog.sv | 27 ++
 rtl/gcd_job_sequencer.sv | 127 ++++++++++++
 tb/tb_gcd_job_sequencer.sv | 391 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gcd_seq_pkg.sv
// Shared types for the GCD job sequencer: FSM state encoding and watchdog sizing.
package gcd_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_SETTLE,
    S_WAIT,
    S_HOLD
  } state_t;

  localparam int TIMEOUT_DEFAULT = 255;
  localparam int WDOG_W          = $clog2(TIMEOUT_DEFAULT + 1);

endpackage

// File: rtl/gcd_watchdog.sv
// Saturating cycle counter for the engine done watchdog; expired while count == TIMEOUT.
module gcd_watchdog #(
  parameter int TIMEOUT = 255,
  parameter int W       = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         enable,
  output logic [W-1:0] count,
  output logic         expired
);

  // Clear restarts at 1: the cycle following clear is the first counted cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= W'(1);
    end else if (enable && (count < W'(TIMEOUT))) begin
      count <= count + W'(1);
    end
  end

  assign expired = (count == W'(TIMEOUT));

endmodule

// File: rtl/gcd_job_sequencer.sv
// Drives one GCD engine from a valid/ready job port and returns tagged results,
// with a zero-operand bypass and a done watchdog.
module gcd_job_sequencer
  import gcd_seq_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             job_valid,
  output logic             job_ready,
  input  logic [WIDTH-1:0] job_a,
  input  logic [WIDTH-1:0] job_b,
  input  logic [TAG_W-1:0] job_tag,
  output logic             eng_start,
  output logic [WIDTH-1:0] eng_a,
  output logic [WIDTH-1:0] eng_b,
  input  logic [WIDTH-1:0] eng_gcd,
  input  logic             eng_done,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_gcd,
  output logic [TAG_W-1:0] res_tag,
  output logic             res_timeout,
  output logic             busy,
  output logic [CNT_W-1:0] jobs_done
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  state_t            state;
  state_t            state_next;
  logic              wd_clear;
  logic              wd_enable;
  logic              wd_expired;
  logic [WD_W-1:0]   wd_count;
  logic              bypass;

  assign bypass = (job_a == '0) || (job_b == '0);

  gcd_watchdog #(
    .TIMEOUT (TIMEOUT),
    .W       (WD_W)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (wd_clear),
    .enable  (wd_enable),
    .count   (wd_count),
    .expired (wd_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (job_valid) state_next = bypass ? S_HOLD : S_ISSUE;
      S_ISSUE:  state_next = S_SETTLE;
      // A done still asserted from the previous job is ignored here.
      S_SETTLE: state_next = S_WAIT;
      S_WAIT:   if (eng_done || wd_expired) state_next = S_HOLD;
      S_HOLD:   if (res_ready) state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // valid/ready: a transfer happens on a rising edge where both are high;
  // the offering side holds its payload stable until that edge.
  always_comb begin
    job_ready = (state == S_IDLE);
    eng_start = (state == S_ISSUE);
    res_valid = (state == S_HOLD);
    busy      = (state != S_IDLE);
    wd_clear  = (state == S_ISSUE);
    wd_enable = (state == S_SETTLE) || (state == S_WAIT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      eng_a       <= '0;
      eng_b       <= '0;
      res_gcd     <= '0;
      res_tag     <= '0;
      res_timeout <= 1'b0;
      jobs_done   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (job_valid) begin
            eng_a       <= job_a;
            eng_b       <= job_b;
            res_tag     <= job_tag;
            res_timeout <= 1'b0;
            res_gcd     <= bypass ? (job_a | job_b) : '0;
          end
        end
        // Done takes priority over a simultaneous watchdog expiry.
        S_WAIT: begin
          if (eng_done) begin
            res_gcd     <= eng_gcd;
            res_timeout <= 1'b0;
          end else if (wd_expired) begin
            res_gcd     <= '0;
            res_timeout <= 1'b1;
          end
        end
        S_HOLD: begin
          if (res_ready && (jobs_done != '1)) begin
            jobs_done <= jobs_done + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_job_sequencer.sv
// Self-checking bench for gcd_job_sequencer with a behavioural GCD engine model.
module tb_gcd_job_sequencer;

  localparam int WIDTH   = 8;
  localparam int TAG_W   = 4;
  localparam int TIMEOUT = 20;
  localparam int CNT_W   = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             job_valid;
  logic             job_ready;
  logic [WIDTH-1:0] job_a;
  logic [WIDTH-1:0] job_b;
  logic [TAG_W-1:0] job_tag;
  logic             eng_start;
  logic [WIDTH-1:0] eng_a;
  logic [WIDTH-1:0] eng_b;
  logic [WIDTH-1:0] eng_gcd;
  logic             eng_done;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_gcd;
  logic [TAG_W-1:0] res_tag;
  logic             res_timeout;
  logic             busy;
  logic [CNT_W-1:0] jobs_done;

  int errors = 0;
  int checks = 0;
  int exp_done = 0;
  int cyc = 0;
  int start_cnt = 0;
  int start_cyc = 0;
  int mode = 0;     // 0 normal, 1 never done, 2 stale done held through one cycle after start
  int lat = 1;
  bit preload = 1'b0;

  gcd_job_sequencer #(
    .WIDTH   (WIDTH),
    .TAG_W   (TAG_W),
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .job_valid   (job_valid),
    .job_ready   (job_ready),
    .job_a       (job_a),
    .job_b       (job_b),
    .job_tag     (job_tag),
    .eng_start   (eng_start),
    .eng_a       (eng_a),
    .eng_b       (eng_b),
    .eng_gcd     (eng_gcd),
    .eng_done    (eng_done),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_gcd     (res_gcd),
    .res_tag     (res_tag),
    .res_timeout (res_timeout),
    .busy        (busy),
    .jobs_done   (jobs_done)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  function automatic int ref_gcd(input int a, input int b);
    int x = a;
    int y = b;
    int t;
    if (x == 0 || y == 0) return x | y;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // cycle counter and eng_start monitor
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (eng_start) begin
      start_cnt <= start_cnt + 1;
      start_cyc <= cyc;
    end
  end

  // behavioural engine: done is a level that stays up until the next start
  logic             m_active;
  logic             m_stale;
  int               m_cnt;
  logic [WIDTH-1:0] m_pend;

  always @(posedge clk) begin
    if (rst) begin
      m_active <= 1'b0;
      m_stale  <= 1'b0;
      m_cnt    <= 0;
      m_pend   <= '0;
      eng_done <= 1'b0;
      eng_gcd  <= '0;
    end else if (preload) begin
      eng_done <= 1'b1;
      eng_gcd  <= 8'd99;
    end else if (eng_start) begin
      m_pend   <= WIDTH'(ref_gcd(int'(eng_a), int'(eng_b)));
      m_cnt    <= lat;
      m_active <= 1'b1;
      m_stale  <= (mode == 2);
      if (mode != 2) eng_done <= 1'b0;
    end else if (m_active) begin
      if (m_stale) begin
        m_stale  <= 1'b0;
        eng_done <= 1'b0;
      end else if (mode != 1) begin
        if (m_cnt <= 1) begin
          eng_done <= 1'b1;
          eng_gcd  <= m_pend;
          m_active <= 1'b0;
        end else begin
          m_cnt <= m_cnt - 1;
        end
      end
    end
  end

  // driver tasks
  task automatic send_job(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [TAG_W-1:0] t, output bit ok, output int acc_cyc);
    int n = 0;
    @(negedge clk);
    while (!job_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    ok = job_ready;
    acc_cyc = 0;
    if (!ok) return;
    job_a = a;
    job_b = b;
    job_tag = t;
    job_valid = 1'b1;
    @(posedge clk);
    #1;
    job_valid = 1'b0;
    acc_cyc = cyc;
  endtask

  task automatic wait_valid(input int budget, output bit ok, output int vcyc);
    ok = 1'b0;
    vcyc = 0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (res_valid) begin
        ok = 1'b1;
        vcyc = cyc;
        break;
      end
    end
  endtask

  task automatic handshake();
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    exp_done++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    job_valid = 1'b0;
    job_a = '0;
    job_b = '0;
    job_tag = '0;
    res_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (job_ready !== 1'b1) begin errors++; $display("FAIL reset_job_ready: got %0b want 1", job_ready); end
    checks++; if (eng_start !== 1'b0) begin errors++; $display("FAIL reset_eng_start: got %0b want 0", eng_start); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid: got %0b want 0", res_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
    checks++; if ({eng_a, eng_b, res_gcd, res_tag, res_timeout} !== '0) begin
      errors++; $display("FAIL reset_data: eng_a=%0d eng_b=%0d res_gcd=%0d res_tag=%0d res_timeout=%0b want all 0",
                         eng_a, eng_b, res_gcd, res_tag, res_timeout);
    end
    checks++; if (jobs_done !== '0) begin errors++; $display("FAIL reset_jobs_done: got %0d want 0", jobs_done); end
  endtask

  task automatic test_basic();
    bit ok;
    int acc, vc, s0;
    mode = 0;
    lat = 1;
    res_ready = 1'b1;
    s0 = start_cnt;
    send_job(8'd54, 8'd24, 4'd3, ok, acc);
    wait_valid(50, ok, vc);
    checks++; if (!ok) begin errors++; $display("FAIL basic_valid: res_valid not seen within 50 cycles"); end
    checks++; if (res_gcd !== 8'd6) begin errors++; $display("FAIL basic_gcd: got %0d want 6", res_gcd); end
    checks++; if (res_tag !== 4'd3) begin errors++; $display("FAIL basic_tag: got %0d want 3", res_tag); end
    checks++; if (res_timeout !== 1'b0) begin errors++; $display("FAIL basic_timeout: got %0b want 0", res_timeout); end
    checks++; if (start_cyc !== acc) begin errors++; $display("FAIL basic_start_cycle: got %0d want %0d", start_cyc, acc); end
    checks++; if (vc - start_cyc !== 3) begin errors++; $display("FAIL basic_latency: got %0d want 3", vc - start_cyc); end
    handshake();
    @(negedge clk);
    checks++; if (jobs_done !== CNT_W'(exp_done)) begin errors++; $display("FAIL basic_jobs_done: got %0d want %0d", jobs_done, exp_done); end
    checks++; if (start_cnt - s0 !== 1) begin errors++; $display("FAIL basic_start_pulses: got %0d want 1", start_cnt - s0); end
  endtask

  task automatic test_bypass();
    bit ok;
    int acc, vc, s0;
    res_ready = 1'b1;
    s0 = start_cnt;
    send_job(8'd0, 8'd17, 4'd1, ok, acc);
    wait_valid(10, ok, vc);
    checks++; if (!ok || vc !== acc) begin errors++; $display("FAIL bypass_latency: valid cycle %0d want %0d (seen=%0b)", vc, acc, ok); end
    checks++; if (res_gcd !== 8'd17) begin errors++; $display("FAIL bypass_gcd: got %0d want 17", res_gcd); end
    handshake();
    send_job(8'd0, 8'd0, 4'd2, ok, acc);
    wait_valid(10, ok, vc);
    checks++; if (!ok || res_gcd !== 8'd0) begin errors++; $display("FAIL bypass_zero: got %0d want 0 (seen=%0b)", res_gcd, ok); end
    checks++; if (res_tag !== 4'd2) begin errors++; $display("FAIL bypass_tag: got %0d want 2", res_tag); end
    handshake();
    @(negedge clk);
    checks++; if (start_cnt !== s0) begin errors++; $display("FAIL bypass_no_start: got %0d pulses want 0", start_cnt - s0); end
  endtask

  task automatic test_backpressure();
    bit ok;
    int acc, vc;
    mode = 0;
    lat = 2;
    res_ready = 1'b0;
    send_job(8'd32, 8'd48, 4'd5, ok, acc);
    wait_valid(50, ok, vc);
    checks++; if (!ok) begin errors++; $display("FAIL bp_valid: res_valid not seen"); end
    for (int i = 0; i < 5; i++) begin
      checks++; if (res_gcd !== 8'd16 || res_valid !== 1'b1 || job_ready !== 1'b0) begin
        errors++; $display("FAIL bp_hold[%0d]: gcd=%0d valid=%0b job_ready=%0b want 16/1/0", i, res_gcd, res_valid, job_ready);
      end
      @(negedge clk);
    end
    handshake();
    @(negedge clk);
    checks++; if (job_ready !== 1'b1 || res_valid !== 1'b0) begin
      errors++; $display("FAIL bp_release: job_ready=%0b res_valid=%0b want 1/0", job_ready, res_valid);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int acc, vc;
    mode = 1;
    res_ready = 1'b1;
    send_job(8'd45, 8'd15, 4'd9, ok, acc);
    wait_valid(80, ok, vc);
    checks++; if (!ok) begin errors++; $display("FAIL to_valid: res_valid not seen within 80 cycles"); end
    checks++; if (res_timeout !== 1'b1) begin errors++; $display("FAIL to_flag: got %0b want 1", res_timeout); end
    checks++; if (res_gcd !== 8'd0) begin errors++; $display("FAIL to_gcd: got %0d want 0", res_gcd); end
    checks++; if (res_tag !== 4'd9) begin errors++; $display("FAIL to_tag: got %0d want 9", res_tag); end
    checks++; if (vc - start_cyc !== TIMEOUT + 1) begin errors++; $display("FAIL to_latency: got %0d want %0d", vc - start_cyc, TIMEOUT + 1); end
    handshake();
    mode = 0;
    lat = 3;
    send_job(8'd45, 8'd15, 4'd4, ok, acc);
    wait_valid(50, ok, vc);
    checks++; if (!ok || res_gcd !== 8'd15 || res_timeout !== 1'b0) begin
      errors++; $display("FAIL to_recover: gcd=%0d timeout=%0b want 15/0 (seen=%0b)", res_gcd, res_timeout, ok);
    end
    handshake();
  endtask

  task automatic test_stale_done();
    bit ok;
    int acc, vc;
    @(negedge clk);
    preload = 1'b1;
    @(posedge clk);
    #1;
    preload = 1'b0;
    mode = 2;
    lat = 4;
    res_ready = 1'b1;
    send_job(8'd100, 8'd50, 4'd6, ok, acc);
    wait_valid(50, ok, vc);
    checks++; if (!ok || res_gcd !== 8'd50) begin errors++; $display("FAIL stale_gcd: got %0d want 50 (seen=%0b)", res_gcd, ok); end
    checks++; if (res_timeout !== 1'b0) begin errors++; $display("FAIL stale_timeout: got %0b want 0", res_timeout); end
    handshake();
    mode = 0;
  endtask

  task automatic test_random();
    bit ok;
    int acc, vc, d;
    logic [WIDTH-1:0] a, b, exp_g;
    logic [TAG_W-1:0] t, exp_t;
    logic [WIDTH-1:0] exp_q[$];
    logic [TAG_W-1:0] tag_q[$];
    mode = 0;
    res_ready = 1'b0;
    for (int i = 0; i < 40; i++) begin
      a = WIDTH'($urandom_range(0, 255));
      b = WIDTH'($urandom_range(0, 255));
      if ($urandom_range(0, 5) == 0) a = '0;
      if ($urandom_range(0, 5) == 0) b = '0;
      t = TAG_W'($urandom_range(0, 15));
      lat = $urandom_range(1, 8);
      exp_q.push_back(WIDTH'(ref_gcd(int'(a), int'(b))));
      tag_q.push_back(t);
      send_job(a, b, t, ok, acc);
      checks++; if (!ok) begin errors++; $display("FAIL rnd_accept[%0d]: job_ready never rose", i); end
      wait_valid(60, ok, vc);
      exp_g = exp_q.pop_front();
      exp_t = tag_q.pop_front();
      checks++; if (!ok || res_gcd !== exp_g || res_tag !== exp_t || res_timeout !== 1'b0) begin
        errors++; $display("FAIL rnd_result[%0d]: a=%0d b=%0d gcd=%0d tag=%0d to=%0b want %0d/%0d/0 (seen=%0b)",
                           i, a, b, res_gcd, res_tag, res_timeout, exp_g, exp_t, ok);
      end
      d = $urandom_range(0, 3);
      repeat (d) @(negedge clk);
      checks++; if (res_valid !== 1'b1 || res_gcd !== exp_g) begin
        errors++; $display("FAIL rnd_stable[%0d]: valid=%0b gcd=%0d want 1/%0d", i, res_valid, res_gcd, exp_g);
      end
      handshake();
      res_ready = 1'b0;
    end
    @(negedge clk);
    checks++; if (jobs_done !== CNT_W'(exp_done)) begin errors++; $display("FAIL rnd_jobs_done: got %0d want %0d", jobs_done, exp_done); end
  endtask

  task automatic test_reset_mid_wait();
    bit ok;
    int acc, vc;
    mode = 0;
    lat = 10;
    res_ready = 1'b1;
    send_job(8'd81, 8'd27, 4'd7, ok, acc);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_done = 0;
    @(negedge clk);
    checks++; if (job_ready !== 1'b1 || busy !== 1'b0 || res_valid !== 1'b0 || eng_start !== 1'b0) begin
      errors++; $display("FAIL rst_ctrl: job_ready=%0b busy=%0b res_valid=%0b eng_start=%0b want 1/0/0/0",
                         job_ready, busy, res_valid, eng_start);
    end
    checks++; if ({eng_a, eng_b, res_gcd, res_tag, res_timeout} !== '0 || jobs_done !== '0) begin
      errors++; $display("FAIL rst_data: eng_a=%0d eng_b=%0d gcd=%0d tag=%0d to=%0b jobs_done=%0d want all 0",
                         eng_a, eng_b, res_gcd, res_tag, res_timeout, jobs_done);
    end
    wait_valid(15, ok, vc);
    checks++; if (ok) begin errors++; $display("FAIL rst_dropped: result appeared for dropped job, gcd=%0d", res_gcd); end
    lat = 3;
    send_job(8'd81, 8'd27, 4'd8, ok, acc);
    wait_valid(50, ok, vc);
    checks++; if (!ok || res_gcd !== 8'd27 || res_tag !== 4'd8) begin
      errors++; $display("FAIL rst_resubmit: gcd=%0d tag=%0d want 27/8 (seen=%0b)", res_gcd, res_tag, ok);
    end
    handshake();
    @(negedge clk);
    checks++; if (jobs_done !== CNT_W'(exp_done)) begin errors++; $display("FAIL rst_jobs_done: got %0d want %0d", jobs_done, exp_done); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bypass();
    test_backpressure();
    test_timeout();
    test_stale_done();
    test_random();
    test_reset_mid_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
